imem_boot_loader: RTL and testbench

Boot-time stage directly upstream of `top`: after reset it accepts a program image as a byte stream and writes it word-by-word into the instruction memory. It holds the core in reset until the image is fully loaded, then releases it. The FSM drives the core's `rst`, so `top` only ever fetches from a fully written instruction memory.

---
 rtl/mips_boot_pkg.sv | 6 +
 rtl/boot_word_assembler.sv | 31 +++
 rtl/imem_boot_loader.sv | 122 ++++++++++++
 tb/tb_imem_boot_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared boot-loader FSM states and image-format constants
package mips_boot_pkg;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR} boot_state_e;
  localparam int BOOT_LEN_BYTES = 2;
  localparam int BOOT_WORD_BYTES = 4;
endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: packs big-endian bytes into 32-bit words, pulsing word_valid on the 4th byte
module boot_word_assembler
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  // byte position and shift; the word is presented combinationally with its last byte
  always_comb begin
    word_valid = in_valid && cnt_q == 2'(BOOT_WORD_BYTES - 1);
    word       = {sr_q, in_data};
    cnt_d      = in_valid ? cnt_q + 2'd1 : cnt_q;
    sr_d       = in_valid ? {sr_q[15:0], in_data} : sr_q;
  end
  // clr discards any partial word
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed image into imem, then releases core reset (checksum byte when IMEM_BOOT_CSUM_EN is defined)
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
`ifdef IMEM_BOOT_CSUM_EN
  localparam boot_state_e TAIL = CSUM;
`else
  localparam boot_state_e TAIL = RUN;
`endif
  boot_state_e       state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   n_q, n_d, idx_q, idx_d, idx_nx;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_q, done_q;
  logic              take, word_valid;
  logic [31:0]       word;
  logic [15:0]       len;
`ifdef IMEM_BOOT_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif
  assign rx_ready   = state_q inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign take       = rx_valid && rx_ready;
  assign len        = {len_hi_q, rx_data};
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign error      = state_q == ERR;
  boot_word_assembler u_asm (
    .clk        (clk),
    .clr        (rst),
    .in_valid   (take && state_q == DATA),
    .in_data    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );
  // next state, word index and one-cycle write strobe
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    idx_d    = idx_q;
    idx_nx   = idx_q + (ADDR_W+1)'(1);
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef IMEM_BOOT_CSUM_EN
    csum_d   = take && state_q != CSUM ? csum_q ^ rx_data : csum_q;
`endif
    case (state_q)
      LEN_HI: if (take) begin
        len_hi_d = rx_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (take) begin
        n_d     = len[ADDR_W:0];
        idx_d   = '0;
        state_d = {1'b0, len} > CAP ? ERR : len == 16'd0 ? TAIL : DATA;
      end
      DATA: if (word_valid) begin
        we_d    = 1'b1;
        addr_d  = idx_q[ADDR_W-1:0];
        wdata_d = word;
        idx_d   = idx_nx;
        state_d = idx_nx == n_q ? TAIL : DATA;
      end
`ifdef IMEM_BOOT_CSUM_EN
      CSUM: if (take) state_d = rx_data == csum_q ? RUN : ERR;
`endif
      default: ;
    endcase
  end
  // state and output registers; core release lags RUN entry by one edge so the last write lands first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LEN_HI;
      len_hi_q   <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= state_q != RUN;
      done_q     <= state_q == RUN;
    end
  end
`ifdef IMEM_BOOT_CSUM_EN
  // running XOR over length and payload bytes
  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader (checksum cases when IMEM_BOOT_CSUM_EN is defined)
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, core_rst, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  logic [39:0] sb[$];
  logic [39:0] exp_w;
  logic [31:0] img[256];
  logic [7:0]  xs = '0;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we) begin
      we_cnt++;
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        check("write", {24'b0, imem_addr, imem_wdata}, {24'b0, exp_w});
      end else check("spurious_we", 64'(imem_we), 64'd0);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    xs       = xs ^ b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    xs     = '0;
    we_cnt = 0;
  endtask

  task automatic load(input int n, input int maxgap, input logic [7:0] csum_flip);
    send(8'(n >> 8), 0);
    send(8'(n), 0);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) begin
        if (k == 3) sb.push_back({8'(w), img[w]});
        send(8'(img[w] >> (24 - 8*k)), int'($urandom_range(0, maxgap)));
      end
`ifdef IMEM_BOOT_CSUM_EN
    send(xs ^ csum_flip, int'($urandom_range(0, maxgap)));
`else
    if (csum_flip != 8'd0) sb.delete();
`endif
  endtask

  task automatic expect_release(input string tag);
    check({tag, "_pre_core_rst"}, 64'(core_rst), 64'd1);
    check({tag, "_pre_done"}, 64'(done), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_core_rst"}, 64'(core_rst), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready", 64'(rx_ready), 64'd1);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    // basic two-word image
    img[0] = 32'hDEADBEEF;
    img[1] = 32'h01234567;
    load(2, 0, 8'd0);
    expect_release("n2");
    send(8'h55, 0);
    send(8'h66, 2);
    check("n2_run_hold", 64'(done), 64'd1);
    check("n2_we_cnt", 64'(we_cnt), 64'd2);
    // reset from RUN reasserts core reset on the same edge
    do_reset();
    check("rerst_core_rst", 64'(core_rst), 64'd1);
    check("rerst_done", 64'(done), 64'd0);
    // same image with random valid gaps
    load(2, 5, 8'd0);
    expect_release("gaps");
    check("gaps_we_cnt", 64'(we_cnt), 64'd2);
    // oversize length
    do_reset();
    send(8'h01, 0);
    send(8'h01, 0);
    check("big_error", 64'(error), 64'd1);
    check("big_rx_ready", 64'(rx_ready), 64'd0);
    send(8'hAA, 1);
    send(8'hBB, 0);
    send(8'hCC, 0);
    send(8'hDD, 0);
    repeat (3) @(posedge clk);
    #1;
    check("big_core_rst", 64'(core_rst), 64'd1);
    check("big_done", 64'(done), 64'd0);
    check("big_we_cnt", 64'(we_cnt), 64'd0);
    // reset mid-word discards the partial word
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hDE, 0);
    send(8'hAD, 0);
    do_reset();
    check("mid_we", 64'(imem_we), 64'd0);
    check("mid_rx_ready", 64'(rx_ready), 64'd1);
    img[0] = 32'h11223344;
    load(1, 0, 8'd0);
    expect_release("mid");
    check("mid_we_cnt", 64'(we_cnt), 64'd1);
`ifdef IMEM_BOOT_CSUM_EN
    do_reset();
    img[0] = 32'hAABBCCDD;
    load(1, 0, 8'd0);
    expect_release("csum_ok");
    do_reset();
    load(1, 0, 8'h01);
    @(posedge clk);
    #1;
    check("csum_bad_error", 64'(error), 64'd1);
    check("csum_bad_core_rst", 64'(core_rst), 64'd1);
    check("csum_bad_done", 64'(done), 64'd0);
`endif
    // full-capacity image: last write at the top address, no wrap
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    load(256, 0, 8'd0);
    expect_release("full");
    repeat (2) @(posedge clk);
    #1;
    check("full_we_cnt", 64'(we_cnt), 64'd256);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
